// File: rtl/trig_ctrl.sv
// trig_ctrl -- threshold trigger sequencer for a streamed ADC sample bus.
//
// Compares each valid sample against a latched threshold using any OR of
// {gt, lt, et}, requires a run of qualifying samples, emits a one-cycle trig
// pulse, optionally waits a holdoff period, then re-arms (continuous) or
// returns to idle (single-shot).
//
// Optional feature: define TRIG_TSTAMP_EN to add a free-running 32-bit
// timestamp counter and the trig_tstamp output.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   adc_data     sample value (operand A)
//   adc_valid    adc_data valid this cycle
//   cfg_thresh   threshold (operand B), latched on arm
//   cfg_sel      condition select {gt, lt, et}, latched on arm
//   cfg_qual     consecutive true samples required (0 acts as 1), latched on arm
//   cfg_holdoff  cycles to wait after a trigger, latched on arm
//   cfg_cont     1 = continuous re-arm, 0 = single-shot, latched on arm
//   arm          start request (level or pulse)
//   disarm       abort to IDLE, overrides everything including a pending trig
//   trig         one-cycle trigger pulse
//   armed        high in ARMED or QUAL
//   busy         high in any state other than IDLE
//   trig_cnt     triggers since reset, wrapping
//   trig_tstamp  (TRIG_TSTAMP_EN only) timestamp of the most recent trigger
//
// States:
//   state     | meaning
//   S_IDLE    | waiting for arm; config inputs are live
//   S_ARMED   | waiting for the first true sample
//   S_QUAL    | counting consecutive true samples
//   S_TRIG    | one-cycle trigger output
//   S_HOLDOFF | post-trigger dead time, samples ignored

module trig_ctrl #(
    parameter int DW = 14,
    parameter int QW = 4,
    parameter int HW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_valid,
    input  logic [DW-1:0] cfg_thresh,
    input  logic [2:0]    cfg_sel,
    input  logic [QW-1:0] cfg_qual,
    input  logic [HW-1:0] cfg_holdoff,
    input  logic          cfg_cont,
    input  logic          arm,
    input  logic          disarm,
    output logic          trig,
    output logic          armed,
    output logic          busy,
    output logic [CW-1:0] trig_cnt
`ifdef TRIG_TSTAMP_EN
    ,
    output logic [31:0]   trig_tstamp
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_QUAL    = 3'd2,
        S_TRIG    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam logic [QW-1:0] Q_ONE = QW'(1);
    localparam logic [HW-1:0] H_ONE = HW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    state_t        state, state_nxt;
    logic [QW-1:0] qcnt, qcnt_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic          load_cfg;
    logic          trig_int;

    logic [DW-1:0] sh_thresh;
    logic [2:0]    sh_sel;
    logic [QW-1:0] sh_qual;
    logic [HW-1:0] sh_holdoff;
    logic          sh_cont;

    // Magnitude compare against the latched threshold.
    logic cmp_gt, cmp_lt, cmp_et, cond;

    always_comb begin
        cmp_gt = (adc_data >  sh_thresh);
        cmp_lt = (adc_data <  sh_thresh);
        cmp_et = (adc_data == sh_thresh);
        cond   = |(sh_sel & {cmp_gt, cmp_lt, cmp_et});
    end

    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        hcnt_nxt  = hcnt;
        load_cfg  = 1'b0;
        trig_int  = 1'b0;

        case (state)
            S_IDLE: begin
                if (arm) begin
                    state_nxt = S_ARMED;
                    load_cfg  = 1'b1;
                end
            end
            S_ARMED: begin
                if (adc_valid && cond) begin
                    // qual of 0 or 1 means the first true sample is enough
                    if (sh_qual <= Q_ONE) begin
                        state_nxt = S_TRIG;
                    end else begin
                        state_nxt = S_QUAL;
                        qcnt_nxt  = Q_ONE;
                    end
                end
            end
            S_QUAL: begin
                // invalid cycles leave the run untouched
                if (adc_valid) begin
                    if (cond) begin
                        if (qcnt + Q_ONE == sh_qual) begin
                            state_nxt = S_TRIG;
                            qcnt_nxt  = '0;
                        end else begin
                            qcnt_nxt = qcnt + Q_ONE;
                        end
                    end else begin
                        state_nxt = S_ARMED;
                        qcnt_nxt  = '0;
                    end
                end
            end
            S_TRIG: begin
                trig_int = 1'b1;
                if (sh_holdoff != '0) begin
                    state_nxt = S_HOLDOFF;
                    hcnt_nxt  = H_ONE;
                end else if (sh_cont) begin
                    state_nxt = S_ARMED;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_HOLDOFF: begin
                if (hcnt == sh_holdoff) begin
                    hcnt_nxt  = '0;
                    state_nxt = sh_cont ? S_ARMED : S_IDLE;
                end else begin
                    hcnt_nxt = hcnt + H_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // disarm wins over arm and suppresses a trigger already in progress
        if (disarm) begin
            state_nxt = S_IDLE;
            qcnt_nxt  = '0;
            hcnt_nxt  = '0;
            load_cfg  = 1'b0;
            trig_int  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            qcnt       <= '0;
            hcnt       <= '0;
            trig_cnt   <= '0;
            sh_thresh  <= '0;
            sh_sel     <= '0;
            sh_qual    <= '0;
            sh_holdoff <= '0;
            sh_cont    <= 1'b0;
        end else begin
            state <= state_nxt;
            qcnt  <= qcnt_nxt;
            hcnt  <= hcnt_nxt;
            if (trig_int) begin
                trig_cnt <= trig_cnt + C_ONE;
            end
            if (load_cfg) begin
                sh_thresh  <= cfg_thresh;
                sh_sel     <= cfg_sel;
                sh_qual    <= cfg_qual;
                sh_holdoff <= cfg_holdoff;
                sh_cont    <= cfg_cont;
            end
        end
    end

    // A reset edge pending in the TRIG cycle cancels the pulse as well.
    assign trig  = trig_int && !rst;
    assign armed = (state == S_ARMED) || (state == S_QUAL);
    assign busy  = (state != S_IDLE);

`ifdef TRIG_TSTAMP_EN
    logic [31:0] tstamp_ctr;

    always_ff @(posedge clk) begin
        if (rst) begin
            tstamp_ctr  <= '0;
            trig_tstamp <= '0;
        end else begin
            tstamp_ctr <= tstamp_ctr + 32'd1;
            if (trig_int) begin
                trig_tstamp <= tstamp_ctr;
            end
        end
    end
`endif

endmodule

// File: doc/trig_ctrl.md
Name: trig_ctrl

Overview:
Sequences a 14-bit threshold trigger on a streamed ADC sample bus. It owns one magnitude-compare datapath instance (A = sample, B = threshold, gt/lt/et select lines) and adds the sequential logic around it: arm/disarm, qualification over N consecutive samples, a trigger pulse, holdoff, and single-shot or continuous re-arm. It sits between the ADC capture stage and the event readout / buffer-freeze logic.

Parameters:
DW, 14, sample and threshold width; must match the compare datapath width.
QW, 4, width of the qualify-count field.
HW, 16, width of the holdoff-count field.
CW, 16, width of the trigger event counter.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
adc_data  input  DW  sample value.
adc_valid  input  1  adc_data is valid this cycle.
cfg_thresh  input  DW  threshold, compare operand B.
cfg_sel  input  3  condition select: {gt, lt, et}; any OR of these is legal.
cfg_qual  input  QW  consecutive true samples required; 0 is treated as 1.
cfg_holdoff  input  HW  cycles to wait after a trigger before re-arming.
cfg_cont  input  1  1 = continuous re-arm; 0 = single-shot.
arm  input  1  start request, level or pulse.
disarm  input  1  abort to IDLE.
trig  output  1  one-cycle trigger pulse.
armed  output  1  high in ARMED or QUAL.
busy  output  1  high in any state other than IDLE.
trig_cnt  output  CW  triggers since reset; wraps at 2^CW.

Behaviour:
- Reset (rst = 1 at a clk edge): state = IDLE; trig, armed, busy = 0; trig_cnt = 0; internal counters = 0; config shadow registers = 0.
- Config shadowing:
  - On the IDLE->ARMED transition, latch cfg_thresh, cfg_sel, cfg_qual, cfg_cont and cfg_holdoff into shadow registers.
  - Config changes while busy have no effect until the next arm from IDLE.
- Compare: cond = (shadow_sel selects a true relation) for adc_data versus shadow_thresh. It is combinational. It is only evaluated when adc_valid = 1.
- IDLE:
  - arm = 1 and disarm = 0 -> ARMED next cycle.
  - Otherwise stay in IDLE.
- ARMED, on a valid sample:
  - cond = 1 and qual <= 1 -> TRIG.
  - cond = 1 and qual > 1 -> QUAL with qcnt = 1.
  - cond = 0 -> stay in ARMED.
  - No valid sample -> stay in ARMED.
- QUAL, on a valid sample:
  - cond = 1 -> qcnt++; when qcnt + 1 == qual -> TRIG.
  - cond = 0 -> ARMED with qcnt = 0.
  - Invalid cycles neither count nor break the run.
- TRIG (one cycle):
  - trig = 1 and trig_cnt++ (wrap).
  - Next state: HOLDOFF if holdoff > 0; else ARMED if cont = 1; else IDLE.
- HOLDOFF:
  - hcnt counts up from 1 each cycle, regardless of adc_valid.
  - When hcnt == holdoff -> ARMED if cont = 1, else IDLE.
  - Samples are ignored in this state.
- Latency: the qualifying sample is registered at edge N; trig is high during cycle N+1.
- Trigger spacing: with holdoff = H and continuous mode, consecutive trig pulses are at least H+2 cycles apart.
- disarm: takes priority over every transition, including TRIG. Any state -> IDLE next cycle with trig = 0, and trig_cnt is not incremented. If arm and disarm are high together, disarm wins.
- cfg_sel = 000: the condition is never true; the block stays armed forever, which is legal.
- Reset mid-operation returns to the reset values above, with no trig pulse.

Optional Feature:
Macro TRIG_TSTAMP_EN.
- Defined:
  - Adds a free-running 32-bit timestamp counter, reset to 0 and wrapping at 2^32.
  - Adds output trig_tstamp [31:0], which latches the counter value during the TRIG cycle and holds it until the next trigger.
  - trig_tstamp resets to 0.
- Undefined: no counter and no trig_tstamp port. All other behaviour is identical.

Test Plan:
1. Basic gt trigger: thresh = 1000, sel = 100, qual = 1, cont = 0, arm pulse; samples 999, 1000, 1001 -> exactly one trig, one cycle after 1001; then state IDLE, busy = 0, trig_cnt = 1.
2. Qualification with gaps: sel = 010 (lt), thresh = 500, qual = 3; samples 100, 100, 600, 100, 100, gap (valid = 0), 100 -> trig only after the last 100; the run of three starts after 600.
3. Continuous with holdoff: et, thresh = 0x2AAA, holdoff = 5, cont = 1; constant 0x2AAA every cycle -> trig every 7 cycles; trig_cnt increments by 1 each time.
4. disarm in QUAL: qual = 4, two true samples, then disarm with a true sample in the same cycle -> IDLE, no trig, trig_cnt unchanged.
5. Config shadowing: arm with thresh = 100; change cfg_thresh to 5000 while armed; sample 200 with gt -> trig fires, using the latched 100.
6. Boundaries: thresh = 0x3FFF, sel = 100 -> never fires. thresh = 0, sel = 011 (lt|et), sample 0 -> fires. trig_cnt preloaded via 2^16 triggers (reduced CW = 4 run) wraps to 0. With TRIG_TSTAMP_EN, trig_tstamp equals the timestamp counter value at the TRIG cycle.
